// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter and the planned receiver:
// parity encodings, transmit FSM state type and the parity-bit helper.
package uart_pkg;

    localparam int PAR_NONE      = 0;
    localparam int PAR_ODD       = 1;
    localparam int PAR_EVEN      = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } tx_state_t;

    // Payload is zero-extended by the caller; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] payload, input int mode);
        logic w_x;
        w_x = ^payload;
        return (mode == PAR_ODD) ? ~w_x : w_x;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO (first-word fall-through read) shared by the UART TX and RX paths.
// A push onto a full FIFO is refused even when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised async serial transmitter with a transmit FIFO; frames go back-to-back with no idle gap.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [DATA_BITS-1:0]         data,
`ifdef UART_TX_BREAK_EN
    input  logic                         send_break,
`endif
    output logic                         tx,
    output logic                         ready,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output tx_state_t                    dbg_state
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t            r_state;
    logic [DW-1:0]        r_div;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_tick;
    logic                 w_stop_done;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_brk_block;
    logic                 w_brk_active;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (we),
        .i_pop   (w_pop),
        .i_data  (data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

`ifdef UART_TX_BREAK_EN
    localparam int BRK_MIN = (DATA_BITS + 2) * CLK_DIV;
    localparam int BKW     = $clog2(BRK_MIN);
    localparam logic [BKW-1:0] BRK_LAST = BKW'(BRK_MIN - 1);

    logic           r_brk;
    logic           r_brk_pend;
    logic [BKW-1:0] r_brk_cnt;
    logic           w_brk_req;
    logic           w_brk_start;

    assign w_brk_req    = send_break || r_brk_pend;
    assign w_brk_start  = (r_state == S_IDLE) && !r_brk && w_brk_req;
    assign w_brk_block  = r_brk || w_brk_req;
    assign w_brk_active = r_brk;

    // A request seen mid-frame is remembered and honoured once the frame has ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk      <= 1'b0;
            r_brk_pend <= 1'b0;
            r_brk_cnt  <= '0;
        end else if (w_brk_start) begin
            r_brk      <= 1'b1;
            r_brk_pend <= 1'b0;
            r_brk_cnt  <= '0;
        end else if (r_brk) begin
            if (r_brk_cnt == BRK_LAST) begin
                if (!send_break) r_brk <= 1'b0;
            end else begin
                r_brk_cnt <= r_brk_cnt + 1'b1;
            end
        end else if (send_break && (r_state != S_IDLE)) begin
            r_brk_pend <= 1'b1;
        end
    end
`else
    assign w_brk_block  = 1'b0;
    assign w_brk_active = 1'b0;
`endif

    assign w_tick      = (r_div == DIV_LAST);
    assign w_stop_done = (r_state == S_STOP) && w_tick && (r_bitcnt == LAST_STOP);
    assign w_pop       = !w_empty && !w_brk_block && ((r_state == S_IDLE) || w_stop_done);

    assign tx        = r_tx;
    assign ready     = !w_full;
    assign busy      = (r_state != S_IDLE) || (level != '0) || w_brk_active;
    assign dbg_state = r_state;

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[0];
            S_PAR:   w_tx_next = r_par;
            default: w_tx_next = 1'b1;
        endcase
        if (w_brk_active) w_tx_next = 1'b0;
    end

    // The line is registered from the state, so tx trails each state by one clock uniformly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_par    <= parity_bit(MAX_DATA_BITS'(w_head), PARITY);
                        r_div    <= '0;
                        r_bitcnt <= '0;
                        r_state  <= S_START;
                    end
                end
                default: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        case (r_state)
                            S_START: r_state <= S_DATA;
                            S_DATA: begin
                                r_shift <= r_shift >> 1;
                                if (r_bitcnt == LAST_DATA) begin
                                    r_bitcnt <= '0;
                                    r_state  <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                                end else begin
                                    r_bitcnt <= r_bitcnt + 1'b1;
                                end
                            end
                            S_PAR: r_state <= S_STOP;
                            S_STOP: begin
                                if (r_bitcnt == LAST_STOP) begin
                                    r_bitcnt <= '0;
                                    if (w_pop) begin
                                        r_shift <= w_head;
                                        r_par   <= parity_bit(MAX_DATA_BITS'(w_head), PARITY);
                                        r_state <= S_START;
                                    end else begin
                                        r_state <= S_IDLE;
                                    end
                                end else begin
                                    r_bitcnt <= r_bitcnt + 1'b1;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: three instances (8N1, 7E2, 7O2 at CLK_DIV=4) checked against
// expected frames; UART_TX_BREAK_EN adds a break-pulse sequence.
module tb_uart_tx_fifo_param;
    import uart_pkg::*;

    localparam int CD = 4;
    localparam int W  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic       we_a = 1'b0, we_b = 1'b0, we_c = 1'b0;
    logic [7:0] data_a = '0;
    logic [6:0] data_b = '0, data_c = '0;
    logic       tx_a, tx_b, tx_c, ready_a, ready_b, ready_c, busy_a, busy_b, busy_c;
    logic [2:0] level_a, level_b, level_c;
    tx_state_t  st_a, st_b, st_c;
`ifdef UART_TX_BREAK_EN
    logic       send_break_a = 1'b0;
`endif

    logic [W-1:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];
    int           starts_a[$];
    logic         mon_en [3] = '{1'b1, 1'b1, 1'b1};
    int           n_checks = 0;
    int           n_fail = 0;

    typedef struct {
        logic [6:0] data;
        logic       par_even;
        logic       par_odd;
    } par_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
        logic [2:0] exp_level;
    } fill_vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .we(we_a), .data(data_a),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break_a),
`endif
        .tx(tx_a), .ready(ready_a), .busy(busy_a), .level(level_a), .dbg_state(st_a));

    uart_tx_fifo_param #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .we(we_b), .data(data_b),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx(tx_b), .ready(ready_b), .busy(busy_b), .level(level_b), .dbg_state(st_b));

    uart_tx_fifo_param #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .we(we_c), .data(data_c),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx(tx_c), .ready(ready_c), .busy(busy_c), .level(level_c), .dbg_state(st_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int idx);
        case (idx)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int idx);
        case (idx)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic pop_exp(input int idx, output logic [W-1:0] e);
        e = '0;
        case (idx)
            0: if (exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); return 1'b1; end
            1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); return 1'b1; end
            default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Samples every clock of a frame: start 0, data LSB first, optional parity, stop 1s.
    task automatic monitor(input int idx, input int db, input int par, input int sb);
        int           nbits, total, mism, b;
        logic [W-1:0] e;
        logic [15:0]  bits;
        logic [8:0]   act_data;
        logic         act_par, t, have, aborted;
        nbits = 1 + db + ((par != 0) ? 1 : 0) + sb;
        total = nbits * CD;
        forever begin
            @(negedge clk);
            if (rst || !mon_en[idx] || get_tx(idx) !== 1'b0) continue;
            if (idx == 0) starts_a.push_back(cyc);
            have = pop_exp(idx, e);
            bits = '1;
            bits[0] = 1'b0;
            for (int i = 0; i < db; i++) bits[1+i] = e[i];
            if (par != 0) bits[1+db] = e[9];
            mism = 0;
            act_data = '0;
            act_par = 1'b0;
            aborted = 1'b0;
            for (int s = 0; s < total; s++) begin
                if (s > 0) begin
                    @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                end
                b = s / CD;
                t = get_tx(idx);
                if (t !== bits[b]) mism++;
                if (s % CD == CD / 2) begin
                    if (b >= 1 && b <= db) act_data[b-1] = t;
                    if (par != 0 && b == 1 + db) act_par = t;
                end
            end
            if (aborted) continue;
            n_checks++;
            if (!have) begin
                n_fail++;
                $display("FAIL frame_%0d: got unexpected frame data 0x%0h, expected no frame", idx, act_data);
            end else if (mism != 0) begin
                n_fail++;
                $display("FAIL frame_%0d: got data 0x%0h par %0d, expected data 0x%0h par %0d (%0d bad samples)",
                         idx, act_data, act_par, e[8:0], e[9], mism);
            end
        end
    endtask

    initial monitor(0, 8, 0, 1);
    initial monitor(1, 7, 2, 2);
    initial monitor(2, 7, 1, 2);

    task automatic write_a(input logic [7:0] d);
        exp_q_a.push_back({2'b00, d});
        we_a = 1'b1;
        data_a = d;
        @(negedge clk);
        we_a = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int max_cyc);
        int n;
        n = 0;
        while (get_busy(idx) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_wait_%0d", idx), get_busy(idx), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        par_vec_t  pv[5];
        fill_vec_t fv[6];
        logic [7:0] singles[4];
        int low;
        pv[0] = '{7'h03, 1'b0, 1'b1};
        pv[1] = '{7'h7F, 1'b1, 1'b0};
        pv[2] = '{7'h00, 1'b0, 1'b1};
        pv[3] = '{7'h15, 1'b1, 1'b0};
        pv[4] = '{7'h6A, 1'b0, 1'b1};
        fv[0] = '{8'hA0, 1'b1, 3'd1};
        fv[1] = '{8'hA1, 1'b1, 3'd1};
        fv[2] = '{8'hA2, 1'b1, 3'd2};
        fv[3] = '{8'hA3, 1'b1, 3'd3};
        fv[4] = '{8'hA4, 1'b1, 3'd4};
        fv[5] = '{8'hA5, 1'b0, 3'd4};
        singles = '{8'h00, 8'hFF, 8'h81, 8'h3C};

        // Reset values, during and after reset.
        repeat (2) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_level", level_a, 0);
        check("rst_state", 32'(st_a), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx", tx_a, 1);
        check("post_rst_tx_b", tx_b, 1);

        // Basic 8N1 frame and idle-line latency.
        write_a(8'h55);
        check("basic_level_after_write", level_a, 1);
        check("basic_busy_after_write", busy_a, 1);
        check("basic_tx_before_pop", tx_a, 1);
        @(negedge clk);
        check("basic_state_start", 32'(st_a), 32'(S_START));
        check("basic_level_after_pop", level_a, 0);
        check("basic_tx_at_pop", tx_a, 1);
        @(negedge clk);
        check("basic_tx_start_latency", tx_a, 0);
        repeat (38) @(negedge clk);
        check("basic_busy_last_stop", busy_a, 1);
        @(negedge clk);
        check("basic_busy_drop", busy_a, 0);
        check("basic_tx_idle", tx_a, 1);
        wait_idle(0, 20);

        for (int i = 0; i < 4; i++) begin
            write_a(singles[i]);
            wait_idle(0, 100);
        end

        // Parity / two stop bits: same payload to the even and odd instances.
        for (int i = 0; i < 5; i++) begin
            exp_q_b.push_back({pv[i].par_even, 2'b00, pv[i].data});
            exp_q_c.push_back({pv[i].par_odd, 2'b00, pv[i].data});
            we_b = 1'b1; data_b = pv[i].data;
            we_c = 1'b1; data_c = pv[i].data;
            @(negedge clk);
            we_b = 1'b0; we_c = 1'b0;
            wait_idle(1, 100);
            wait_idle(2, 100);
        end

        // FIFO fill: six writes, the sixth must be refused.
        starts_a.delete();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_ready_%0d", i), ready_a, fv[i].exp_ready);
            if (fv[i].exp_ready) exp_q_a.push_back({2'b00, fv[i].data});
            we_a = 1'b1;
            data_a = fv[i].data;
            @(negedge clk);
            check($sformatf("fill_level_%0d", i), level_a, fv[i].exp_level);
        end
        we_a = 1'b0;
        wait_idle(0, 400);
        check("fill_frame_count", starts_a.size(), 5);
        for (int i = 1; i < starts_a.size(); i++)
            check($sformatf("fill_gap_%0d", i), starts_a[i] - starts_a[i-1], 40);

        // Push on the exact stop-end pop cycle with two entries queued.
        write_a(8'h10);
        write_a(8'h21);
        write_a(8'h32);
        repeat (38) @(negedge clk);
        check("pp_level_before", level_a, 2);
        check("pp_state_stop", 32'(st_a), 32'(S_STOP));
        exp_q_a.push_back({2'b00, 8'h43});
        we_a = 1'b1;
        data_a = 8'h43;
        @(negedge clk);
        we_a = 1'b0;
        check("pp_level_same", level_a, 2);
        check("pp_state_start", 32'(st_a), 32'(S_START));
        wait_idle(0, 400);

`ifdef UART_TX_BREAK_EN
        // One-clock break pulse with a write held back until the break ends.
        mon_en[0] = 1'b0;
        send_break_a = 1'b1;
        @(negedge clk);
        send_break_a = 1'b0;
        check("brk_busy", busy_a, 1);
        low = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 3) begin
                exp_q_a.push_back({2'b00, 8'hC3});
                we_a = 1'b1;
                data_a = 8'hC3;
            end else begin
                we_a = 1'b0;
            end
            @(negedge clk);
            if (tx_a === 1'b0) low++;
            else if (low > 0) break;
        end
        we_a = 1'b0;
        mon_en[0] = 1'b1;
        check("brk_low_len", low, 40);
        wait_idle(0, 200);
`else
        low = 0;
`endif

        // Asynchronous reset in the middle of data bit 3.
        write_a(8'h30);
        write_a(8'h11);
        repeat (18) @(negedge clk);
        check("mid_rst_tx_low_before", tx_a, 0);
        check("mid_rst_level_before", level_a, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx_async", tx_a, 1);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_ready", ready_a, 1);
        check("mid_rst_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q_a.delete();
        @(negedge clk);
        write_a(8'h0F);
        wait_idle(0, 100);

        check("queue_a_drained", exp_q_a.size(), 0);
        check("queue_b_drained", exp_q_b.size(), 0);
        check("queue_c_drained", exp_q_c.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
